// File: rtl/micro_sequencer.sv
// Microsequencer for the 29-bit control store: issues next-address/jump mode,
// decodes returned microinstructions into registered datapath controls.
module micro_sequencer #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter logic [7:0] HALT_ADDR  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [28:0] MIR,
  input  logic        alu_z,
  input  logic        mem_ack,
  output logic [7:0]  addr,
  output logic [1:0]  JMP,
  output logic        Z,
  output logic [4:0]  rd_sel,
  output logic [7:0]  wr_en,
  output logic [2:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, MEMWAIT, HALT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  addr_next;
  logic [1:0]  jmp_next;
  logic        z_next;
  logic [4:0]  rd_sel_next;
  logic [7:0]  wr_en_next;
  logic [2:0]  alu_op_next;
  logic        mem_rd_next, mem_wr_next;

  logic [7:0] mir_next;
  logic [1:0] mir_jfld;
  logic [4:0] mir_rsel;
  logic [7:0] mir_wen;
  logic [2:0] mir_aop;
  logic [2:0] mir_mop;
  logic       is_read, is_write, is_halt;

  assign mir_next = MIR[28:21];
  assign mir_jfld = MIR[20:19];
  assign mir_rsel = MIR[18:14];
  assign mir_wen  = MIR[13:6];
  assign mir_aop  = MIR[5:3];
  assign mir_mop  = MIR[2:0];

  assign is_read  = (mir_mop == 3'b001);
  assign is_write = (mir_mop == 3'b010);
  assign is_halt  = (mir_next == HALT_ADDR) && (mir_jfld == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr      <= START_ADDR;
      JMP       <= 2'b00;
      Z         <= 1'b0;
      rd_sel    <= '0;
      wr_en     <= '0;
      alu_op    <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr      <= addr_next;
      JMP       <= jmp_next;
      Z         <= z_next;
      rd_sel    <= rd_sel_next;
      wr_en     <= wr_en_next;
      alu_op    <= alu_op_next;
      mem_rd    <= mem_rd_next;
      mem_wr    <= mem_wr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr;
    jmp_next    = JMP;
    z_next      = Z;
    rd_sel_next = rd_sel;
    wr_en_next  = '0;
    alu_op_next = alu_op;
    mem_rd_next = mem_rd;
    mem_wr_next = mem_wr;

    case (state_reg)
      RUN: begin
        rd_sel_next = mir_rsel;
        alu_op_next = mir_aop;
        if (mir_aop != 3'd0) z_next = alu_z;
        if (is_read || is_write) begin
          // Address and jump mode stay put so the store keeps returning this word.
          mem_rd_next = is_read;
          mem_wr_next = is_write;
          state_next  = MEMWAIT;
        end else begin
          wr_en_next  = mir_wen;
          mem_rd_next = 1'b0;
          mem_wr_next = 1'b0;
          if (is_halt) begin
            addr_next  = START_ADDR;
            jmp_next   = 2'b00;
            state_next = HALT;
          end else begin
            addr_next = mir_next;
            jmp_next  = mir_jfld;
          end
        end
      end
      MEMWAIT: begin
        if (mem_ack) begin
          wr_en_next  = mir_wen;
          mem_rd_next = 1'b0;
          mem_wr_next = 1'b0;
          if (is_halt) begin
            addr_next  = START_ADDR;
            jmp_next   = 2'b00;
            state_next = HALT;
          end else begin
            addr_next  = mir_next;
            jmp_next   = mir_jfld;
            state_next = RUN;
          end
        end
      end
      default: begin
        // IDLE and HALT: park on the start address with all controls quiet.
        addr_next   = START_ADDR;
        jmp_next    = 2'b00;
        rd_sel_next = '0;
        alu_op_next = '0;
        mem_rd_next = 1'b0;
        mem_wr_next = 1'b0;
        if (start) state_next = RUN;
      end
    endcase
  end

  assign busy = (state_reg == RUN) || (state_reg == MEMWAIT);
  assign done = (state_reg == HALT);

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: behavioural model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [28:0] MIR = '0;
  logic        alu_z = 1'b0;
  logic        mem_ack = 1'b0;
  logic [7:0]  addr;
  logic [1:0]  JMP;
  logic        Z;
  logic [4:0]  rd_sel;
  logic [7:0]  wr_en;
  logic [2:0]  alu_op;
  logic        mem_rd, mem_wr, busy, done;

  int checks = 0;
  int failures = 0;

  micro_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .MIR(MIR), .alu_z(alu_z),
    .mem_ack(mem_ack), .addr(addr), .JMP(JMP), .Z(Z), .rd_sel(rd_sel),
    .wr_en(wr_en), .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [28:0] mk(input logic [7:0] nxt, input logic [1:0] jf,
                                     input logic [4:0] rs, input logic [7:0] we,
                                     input logic [2:0] ao, input logic [2:0] mo);
    return {nxt, jf, rs, we, ao, mo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the program mode plus the expected value of every output.
  typedef enum int {M_IDLE, M_RUN, M_WAIT, M_HALT} mode_t;
  mode_t      m_mode = M_IDLE;
  logic [7:0] e_addr = 8'h00;
  logic [1:0] e_jmp = 2'b00;
  logic       e_z = 1'b0;
  logic [4:0] e_rsel = '0;
  logic [7:0] e_wen = '0;
  logic [2:0] e_aop = '0;
  logic       e_rd = 1'b0, e_wr = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = M_IDLE; e_addr = 8'h00; e_jmp = 2'b00; e_z = 1'b0;
      e_rsel = '0; e_wen = '0; e_aop = '0; e_rd = 1'b0; e_wr = 1'b0;
    end else begin
      logic [7:0] n; logic [1:0] j; logic [2:0] mop; logic halt_word;
      n = MIR[28:21]; j = MIR[20:19]; mop = MIR[2:0];
      halt_word = (n == 8'hFF) && (j == 2'b00);
      if (m_mode == M_IDLE || m_mode == M_HALT) begin
        e_addr = 8'h00; e_jmp = 2'b00; e_rsel = '0; e_wen = '0; e_aop = '0;
        e_rd = 1'b0; e_wr = 1'b0;
        if (start) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        e_rsel = MIR[18:14]; e_aop = MIR[5:3];
        if (MIR[5:3] != 0) e_z = alu_z;
        if (mop == 3'd1 || mop == 3'd2) begin
          e_wen = '0; e_rd = (mop == 3'd1); e_wr = (mop == 3'd2); m_mode = M_WAIT;
        end else begin
          e_wen = MIR[13:6]; e_rd = 1'b0; e_wr = 1'b0;
          if (halt_word) begin e_addr = 8'h00; e_jmp = 2'b00; m_mode = M_HALT; end
          else begin e_addr = n; e_jmp = j; end
        end
      end else begin
        e_wen = '0;
        if (mem_ack) begin
          e_wen = MIR[13:6]; e_rd = 1'b0; e_wr = 1'b0;
          if (halt_word) begin e_addr = 8'h00; e_jmp = 2'b00; m_mode = M_HALT; end
          else begin e_addr = n; e_jmp = j; m_mode = M_RUN; end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("cycle",
        {1'b0, addr, JMP, Z, rd_sel, wr_en, alu_op, mem_rd, mem_wr, busy, done},
        {1'b0, e_addr, e_jmp, e_z, e_rsel, e_wen, e_aop, e_rd, e_wr,
         (m_mode == M_RUN || m_mode == M_WAIT), (m_mode == M_HALT)});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with an all-ones MIR, held for several cycles.
    rst = 1'b1; MIR = '1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rst_addr", addr, 8'h00);
      chk("rst_ctl", {JMP, Z, rd_sel, wr_en, alu_op, mem_rd, mem_wr, busy, done}, 0);
    end
    rst = 1'b0; MIR = '0;
    cyc(); cyc();
    chk("idle_busy", busy, 0);

    // Straight sequence.
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_no_ctl", wr_en, 8'h00);
    MIR = mk(8'd5, 2'b00, 5'd3, 8'h04, 3'd2, 3'd0); alu_z = 1'b1; cyc();
    chk("seq_addr", addr, 8'd5);
    chk("seq_wen", wr_en, 8'h04);
    chk("seq_rsel", rd_sel, 5'd3);
    chk("seq_aop", alu_op, 3'd2);
    chk("seq_z", Z, 1'b1);
    MIR = mk(8'd7, 2'b00, 5'd0, 8'h00, 3'd0, 3'd0); alu_z = 1'b0; cyc();
    chk("seq2_wen", wr_en, 8'h00);
    chk("seq2_aop", alu_op, 3'd0);
    chk("seq2_z_hold", Z, 1'b1);
    chk("seq2_addr", addr, 8'd7);

    // Memory read stall then ack.
    MIR = mk(8'd9, 2'b00, 5'd1, 8'h10, 3'd0, 3'd1); cyc();
    for (int i = 0; i < 4; i++) begin
      chk("stall_rd", mem_rd, 1'b1);
      chk("stall_wen", wr_en, 8'h00);
      chk("stall_addr", addr, 8'd7);
      cyc();
    end
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("ack_wen", wr_en, 8'h10);
    chk("ack_addr", addr, 8'd9);
    chk("ack_rd", mem_rd, 1'b0);
    chk("ack_busy", busy, 1'b1);
    MIR = '0; cyc();
    chk("ack_pulse", wr_en, 8'h00);

    // Branch / dispatch and Z hold.
    MIR = mk(8'd3, 2'b01, 5'd0, 8'h00, 3'd0, 3'd0); cyc();
    chk("jmp_z", JMP, 2'b01);
    MIR = mk(8'd4, 2'b10, 5'd0, 8'h00, 3'd0, 3'd0); cyc();
    chk("jmp_ir", JMP, 2'b10);
    MIR = mk(8'd4, 2'b00, 5'd0, 8'h00, 3'd1, 3'd0); alu_z = 1'b0; cyc();
    chk("z_clear", Z, 1'b0);
    MIR = mk(8'd4, 2'b00, 5'd0, 8'h00, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      alu_z = ~alu_z; cyc();
      chk("z_hold", Z, 1'b0);
    end
    MIR = mk(8'hFF, 2'b01, 5'd0, 8'h00, 3'd0, 3'd0); cyc();
    chk("ff_jump_addr", addr, 8'hFF);
    chk("ff_jump_busy", busy, 1'b1);

    // Ignored inputs in RUN.
    start = 1'b1; MIR = mk(8'd6, 2'b00, 5'd0, 8'h00, 3'd0, 3'd0); cyc(); start = 1'b0;
    chk("start_in_run", addr, 8'd6);
    mem_ack = 1'b1; MIR = mk(8'd8, 2'b00, 5'd0, 8'h00, 3'd0, 3'd0); cyc(); mem_ack = 1'b0;
    chk("ack_in_run", {addr, busy}, {8'd8, 1'b1});

    // Halt and restart.
    MIR = mk(8'hFF, 2'b00, 5'd2, 8'h01, 3'd0, 3'd0); cyc();
    chk("halt_wen", wr_en, 8'h01);
    chk("halt_state", {done, busy, addr}, {1'b1, 1'b0, 8'h00});
    MIR = '0; cyc();
    chk("halt_quiet", {wr_en, rd_sel}, 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart", {busy, done}, 2'b10);

    // Halt evaluated at ack time on a memory write word.
    MIR = mk(8'hFF, 2'b00, 5'd0, 8'h20, 3'd0, 3'd2); cyc();
    chk("wr_req", mem_wr, 1'b1);
    cyc();
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("wr_halt", {wr_en, mem_wr, done}, {8'h20, 1'b0, 1'b1});
    MIR = '0; start = 1'b1; cyc(); start = 1'b0;

    // Reset asserted mid-MEMWAIT clears the request without a clock edge.
    MIR = mk(8'd1, 2'b00, 5'd0, 8'h00, 3'd0, 3'd2); cyc();
    chk("pre_rst_wr", mem_wr, 1'b1);
    #1 rst = 1'b1;
    #1 chk("async_rst_wr", {mem_wr, busy}, 2'b00);
    #1 rst = 1'b0;
    MIR = '0; cyc();
    chk("post_rst_idle", {busy, done, addr}, 0);

    // start and mem_ack together in IDLE: only start acts.
    start = 1'b1; mem_ack = 1'b1; cyc(); start = 1'b0; mem_ack = 1'b0;
    chk("idle_start_ack", {busy, mem_rd, mem_wr, wr_en}, {1'b1, 10'd0});
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microsequencer that sits on the consuming end of the 29-bit control store.
- Drives the control store's next-address (addr) and jump-mode (JMP) inputs, and latches the ALU zero flag that feeds its Z input.
- Decodes each returned microinstruction word (MIR) into registered datapath controls.
- Handles start/halt sequencing and stalls on memory operations until the memory acknowledges.

Parameters:
- START_ADDR, 8'h00, micro-address issued in IDLE/HALT and fetched first after start.
- HALT_ADDR, 8'hFF, a NEXT field equal to this value with JMP field 00 terminates the microprogram.

Ports:
- clk  input  1  system clock; this block acts on posedge, the control store fetches on negedge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse that launches the microprogram from START_ADDR.
- MIR  input  29  microinstruction from the control store.
- alu_z  input  1  ALU zero result for the current cycle.
- mem_ack  input  1  memory completion strobe.
- addr  output  8  next micro-address to the control store.
- JMP  output  2  jump mode to the control store: 00 = addr, 10 = IR dispatch, x1 = Z branch.
- Z  output  1  latched zero flag to the control store.
- rd_sel  output  5  bus source select.
- wr_en  output  8  register write-enable vector.
- alu_op  output  3  ALU operation, 0 = none.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request.
- busy  output  1  high in RUN or MEMWAIT.
- done  output  1  high in HALT.

Behaviour:
- MIR field layout:
  - [28:21] NEXT
  - [20:19] JFLD
  - [18:14] RSEL
  - [13:6] WEN
  - [5:3] AOP
  - [2:0] MOP: 001 = read, 010 = write, any other value = no memory op.
- Reset (asynchronous, any state): state = IDLE; addr = START_ADDR; JMP = 00; Z = 0; all other outputs = 0.
- All outputs are registered and update on posedge clk only.
- IDLE:
  - addr = START_ADDR, JMP = 00, controls = 0.
  - start = 1 -> RUN.
  - No controls are issued on the start edge; the first decode happens on the next posedge.
- RUN, every posedge:
  - Registers rd_sel <= RSEL, alu_op <= AOP.
  - Registers addr <= NEXT, JMP <= JFLD.
  - If AOP != 0, Z <= alu_z; otherwise Z holds.
  - If MOP is none: wr_en <= WEN; stay in RUN.
  - If MOP is read/write: wr_en <= 0; mem_rd/mem_wr <= 1 accordingly; addr and JMP are NOT updated (they hold their prior values); -> MEMWAIT.
  - If NEXT == HALT_ADDR and JFLD == 00 (and MOP is none): issue this word's controls, then on the same edge set state = HALT, addr <= START_ADDR, JMP <= 00. In the following cycle controls return to 0.
- MEMWAIT:
  - addr, JMP, Z, rd_sel, alu_op and mem_rd/mem_wr are held; wr_en = 0.
  - mem_ack = 1 -> wr_en <= WEN (one cycle), addr <= NEXT, JMP <= JFLD, mem_rd/mem_wr <= 0, -> RUN.
  - A halt condition on a memory word is evaluated at ack time, giving -> HALT instead of RUN.
- HALT:
  - done = 1; controls = 0; addr = START_ADDR.
  - start = 1 -> RUN (restart).
- Pulse rules: every control output is a one-cycle pulse per microinstruction; nothing persists to the following cycle unless the next MIR re-issues it.
- Ignored inputs:
  - start in RUN or MEMWAIT has no effect.
  - mem_ack outside MEMWAIT has no effect.
  - If start and mem_ack are both high in IDLE, only start acts.
- No wait timeout; MEMWAIT persists indefinitely until mem_ack.
- NEXT = 8'hFF with JFLD != 00 is a normal jump, not a halt.
- Reset asserted mid-MEMWAIT drops mem_rd/mem_wr immediately (asynchronously).

Test Plan:
- Reset then idle: assert rst with MIR = all ones -> addr = 00, JMP = 00, Z = 0, busy = 0, done = 0, all controls 0; hold 5 cycles -> unchanged.
- Straight sequence: start pulse, then MIR = {NEXT = 8'd5, JFLD = 00, RSEL = 3, WEN = 8'h04, AOP = 2, MOP = 0} with alu_z = 1 -> at next posedge addr = 5, wr_en = 04, rd_sel = 3, alu_op = 2, Z = 1; one cycle later with MIR = 0 -> wr_en = 0, alu_op = 0, Z stays 1.
- Memory stall: MIR with MOP = 001, WEN = 8'h10, NEXT = 9 -> mem_rd = 1, wr_en = 0, addr unchanged for 4 cycles without ack; mem_ack pulse -> wr_en = 10 for one cycle, addr = 9, mem_rd = 0, state RUN.
- Branch/dispatch: MIR JFLD = 01 -> JMP = 01 on the next edge; JFLD = 10 -> JMP = 10; AOP = 0 with alu_z toggling -> Z unchanged.
- Halt and restart: MIR NEXT = FF, JFLD = 00, WEN = 8'h01 -> wr_en = 01 for one cycle, then done = 1, busy = 0, addr = 00; a start pulse -> busy = 1, done = 0.
- Reset mid-operation and ignored inputs: in MEMWAIT with mem_wr = 1, assert rst -> mem_wr = 0 immediately, state IDLE. Start pulse during RUN -> no change. mem_ack in RUN -> no change.
